// File: rtl/instr_encoder_fifo.sv
// -----------------------------------------------------------------------------
// instr_encoder_fifo
//
// Purpose:
//   Turns field-level instruction requests (class, funct3, register indices,
//   raw byte-valued immediate) into RV32I machine words and queues them in a
//   DEPTH-entry FIFO. Illegal requests are consumed, dropped, and flagged with
//   a one-cycle err pulse.
//
// Handshakes (both sides use the same valid/ready rule):
//   A transfer happens on a rising clk edge exactly when valid and ready are
//   both 1 in the cycle before that edge. Valid never depends on ready.
//   in_ready depends only on occupancy (never on out_ready), and out_valid
//   depends only on occupancy (never on in_valid), so no combinational path
//   runs from either input handshake to the other side.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid & in_ready  (count < DEPTH)
//   in_type    1=R 2=LOAD 3=I_IMM 4=LUI 5=AUIPC 6=JAL 7=JALR 8=BRANCH 9=STORE
//   in_funct3  funct3 field
//   in_alt     selects funct7 = 0100000 when 1, 0000000 when 0
//   in_rd      destination register
//   in_rs1     source register 1
//   in_rs2     source register 2
//   in_imm     immediate as a plain byte value (not pre-shifted)
//   out_valid  FIFO head holds a word
//   out_ready  head is popped when out_valid & out_ready
//   out_instr  encoded word at the head, 0 while out_valid is 0
//   count      current occupancy, 0..DEPTH
//   err        one-cycle pulse after an accepted illegal request
// -----------------------------------------------------------------------------
module instr_encoder_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_type,
  input  logic [2:0]               in_funct3,
  input  logic                     in_alt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Instruction classes as presented on in_type
  localparam logic [3:0] T_R      = 4'd1;
  localparam logic [3:0] T_LOAD   = 4'd2;
  localparam logic [3:0] T_I_IMM  = 4'd3;
  localparam logic [3:0] T_LUI    = 4'd4;
  localparam logic [3:0] T_AUIPC  = 4'd5;
  localparam logic [3:0] T_JAL    = 4'd6;
  localparam logic [3:0] T_JALR   = 4'd7;
  localparam logic [3:0] T_BRANCH = 4'd8;
  localparam logic [3:0] T_STORE  = 4'd9;

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_I_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_BASE = 7'b0000000;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          err_q;

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic [6:0]  f7;
  logic [31:0] enc_word;

  assign f7 = in_alt ? F7_ALT : F7_BASE;

  always_comb begin
    enc_word = 32'h0000_0000;
    case (in_type)
      T_R:      enc_word = {f7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      T_LOAD:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      T_I_IMM: begin
        // SLLI/SRLI/SRAI carry a 5-bit shift amount and a funct7 field
        // where the other I-type ops carry a 12-bit immediate.
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          enc_word = {f7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_I_IMM};
        end else begin
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I_IMM};
        end
      end
      T_LUI:    enc_word = {in_imm[31:12], in_rd, OP_LUI};
      T_AUIPC:  enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
      T_JAL:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11],
                            in_imm[19:12], in_rd, OP_JAL};
      // JALR has a fixed funct3 of 000; the request's funct3 is not used.
      T_JALR:   enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      T_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                            in_funct3, in_imm[4:1], in_imm[11], OP_BRANCH};
      T_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], OP_STORE};
      default:  enc_word = 32'h0000_0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Legality check
  // ---------------------------------------------------------------------------
  logic enc_illegal;

  always_comb begin
    enc_illegal = 1'b0;
    case (in_type)
      T_R: begin
        // Only ADD/SUB (000) and SRL/SRA (101) have an alternate funct7.
        if (in_alt && !(in_funct3 == 3'b000 || in_funct3 == 3'b101)) begin
          enc_illegal = 1'b1;
        end
      end
      T_LOAD: begin
        if (in_funct3 == 3'b011 || in_funct3 == 3'b110 || in_funct3 == 3'b111) begin
          enc_illegal = 1'b1;
        end
      end
      T_I_IMM, T_LUI, T_AUIPC, T_JALR: enc_illegal = 1'b0;
      T_JAL: begin
        // Jump targets are halfword aligned; bit 0 cannot be encoded.
        if (in_imm[0]) begin
          enc_illegal = 1'b1;
        end
      end
      T_BRANCH: begin
        if (in_funct3 == 3'b010 || in_funct3 == 3'b011 || in_imm[0]) begin
          enc_illegal = 1'b1;
        end
      end
      T_STORE: begin
        if (in_funct3 > 3'b010) begin
          enc_illegal = 1'b1;
        end
      end
      default: enc_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic push;
  logic pop;

  // Full FIFO refuses requests even if the head is popped in the same cycle.
  assign in_ready  = (cnt < DEPTH_C);
  assign out_valid = (cnt != '0);

  assign accept = in_valid && in_ready;
  assign push   = accept && !enc_illegal;
  assign pop    = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Storage: data is not reset; validity comes from cnt alone.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
      err_q <= accept && enc_illegal;
    end
  end

  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0000_0000;
  assign count     = cnt;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_fifo.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_fifo
//
// Directed bench for instr_encoder_fifo. A reference model keeps the expected
// FIFO contents as a queue of words built from the RV32I field layouts, and a
// compare process checks every DUT output against it on each falling edge.
// Literal checks at key points pin the model to hand-computed encodings.
// -----------------------------------------------------------------------------
module tb_instr_encoder_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_type;
  logic [2:0]    in_funct3;
  logic          in_alt;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [CW-1:0] count;
  logic          err;

  instr_encoder_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_funct3 (in_funct3),
    .in_alt    (in_alt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .count     (count),
    .err       (err)
  );

  // ---------------------------------------------------------------------------
  // Counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  bit          err_exp = 1'b0;

  function automatic bit model_illegal(input logic [31:0] t, input logic [31:0] f3,
                                       input logic [31:0] alt, input logic [31:0] imm);
    bit bad;
    bad = 1'b0;
    if (t == 0 || t > 9)                                  bad = 1'b1;
    if (t == 8 && (f3 == 2 || f3 == 3))                   bad = 1'b1;
    if (t == 2 && (f3 == 3 || f3 == 6 || f3 == 7))        bad = 1'b1;
    if (t == 9 && f3 > 2)                                 bad = 1'b1;
    if (t == 1 && alt == 1 && !(f3 == 0 || f3 == 5))      bad = 1'b1;
    if ((t == 6 || t == 8) && imm[0])                     bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_encode(input logic [31:0] t, input logic [31:0] f3,
                                               input logic [31:0] alt, input logic [31:0] rd,
                                               input logic [31:0] rs1, input logic [31:0] rs2,
                                               input logic [31:0] imm);
    logic [31:0] f7;
    logic [31:0] w;
    f7 = (alt == 1) ? 32'h20 : 32'h0;
    w  = 32'h0;
    case (t)
      1: w = 32'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
      2: w = 32'h03 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      3: begin
        if (f3 == 1 || f3 == 5)
          w = 32'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'h1F) << 20) | (f7 << 25);
        else
          w = 32'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      end
      4: w = (imm & 32'hFFFF_F000) | (rd << 7) | 32'h37;
      5: w = (imm & 32'hFFFF_F000) | (rd << 7) | 32'h17;
      6: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000) | (rd << 7) | 32'h6F;
      7: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      8: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
             (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) |
             (((imm >> 11) & 32'h1) << 7) | 32'h63;
      9: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
             ((imm & 32'h1F) << 7) | 32'h23;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      bit acc;
      bit pp;
      bit bad;
      acc = in_valid && (exp_q.size() < DEPTH);
      pp  = (exp_q.size() != 0) && out_ready;
      bad = model_illegal(32'(in_type), 32'(in_funct3), 32'(in_alt), in_imm);
      if (pp) void'(exp_q.pop_front());
      if (acc && !bad)
        exp_q.push_back(model_encode(32'(in_type), 32'(in_funct3), 32'(in_alt), 32'(in_rd),
                                     32'(in_rs1), 32'(in_rs2), in_imm));
      err_exp = acc && bad;
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(exp_q.size()));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      check("out_instr", out_instr, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
      check("err", 32'(err), 32'(err_exp));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge; return at the next falling edge)
  // ---------------------------------------------------------------------------
  task automatic send(input int t, input int f3, input int alt, input int rd,
                      input int rs1, input int rs2, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_type   = 4'(t);
    in_funct3 = 3'(f3);
    in_alt    = 1'(alt);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 2 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_done", 32'(exp_q.size()), 32'h0);
    out_ready = 1'b0;
    idle(1);
  endtask

  // Send one request into an empty FIFO and pin the head against a literal.
  task automatic expect_head(input string name, input int t, input int f3, input int alt,
                             input int rd, input int rs1, input int rs2,
                             input logic [31:0] imm, input logic [31:0] word);
    out_ready = 1'b0;
    send(t, f3, alt, rd, rs1, rs2, imm);
    in_valid = 1'b0;
    check(name, out_instr, word);
    check({name, "_valid"}, 32'(out_valid), 32'h1);
    drain();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_type = '0; in_funct3 = '0; in_alt = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_count", 32'(count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    idle(1);

    // Pinned encodings
    expect_head("add",     1, 0, 0, 3, 1, 2, 32'h0,         32'h0020_81B3);
    expect_head("sub",     1, 0, 1, 3, 1, 2, 32'h0,         32'h4020_81B3);
    expect_head("addi_m1", 3, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFF0_0093);
    expect_head("lui",     4, 0, 0, 5, 0, 0, 32'h1234_5000, 32'h1234_52B7);
    expect_head("beq_p8",  8, 0, 0, 0, 1, 2, 32'h0000_0008, 32'h0020_8463);
    expect_head("jal",     6, 0, 0, 1, 0, 0, 32'h0000_0800, 32'h0010_00EF);
    expect_head("sw_m4",   9, 2, 0, 0, 2, 3, 32'hFFFF_FFFC, 32'hFE31_2E23);

    // Misaligned branch: err pulse for one cycle, no enqueue
    send(8, 0, 0, 0, 1, 2, 32'h0000_0009);
    in_valid = 1'b0;
    check("beq_odd_err", 32'(err), 32'h1);
    check("beq_odd_count", 32'(count), 32'h0);
    idle(1);
    check("beq_odd_err_clr", 32'(err), 32'h0);

    // Type 0: err for exactly one cycle
    send(0, 0, 0, 1, 1, 1, 32'h0);
    in_valid = 1'b0;
    check("type0_err", 32'(err), 32'h1);
    check("type0_valid", 32'(out_valid), 32'h0);
    idle(1);
    check("type0_err_clr", 32'(err), 32'h0);

    // Mixed legal/illegal stream with a consumer always ready
    out_ready = 1'b1;
    send(6, 0, 0, 1, 0, 0, 32'h0000_0003);   // JAL odd -> illegal
    send(7, 5, 0, 1, 2, 0, 32'h0000_0010);   // JALR, funct3 ignored
    send(9, 3, 0, 0, 2, 3, 32'h0000_0004);   // store f3 011 -> illegal
    send(2, 4, 0, 4, 5, 0, 32'h0000_07FF);   // LBU
    send(2, 3, 0, 4, 5, 0, 32'h0000_0001);   // load f3 011 -> illegal
    send(2, 6, 0, 4, 5, 0, 32'h0000_0001);   // load f3 110 -> illegal
    send(3, 5, 1, 6, 7, 0, 32'h0000_001F);   // SRAI
    send(3, 1, 0, 6, 7, 0, 32'h0000_0025);   // SLLI, only imm[4:0]
    send(5, 0, 0, 10, 0, 0, 32'hABCD_E123);  // AUIPC
    send(8, 7, 0, 0, 3, 4, 32'hFFFF_F000);   // BGEU -4096
    send(8, 2, 0, 0, 3, 4, 32'h0000_0010);   // branch f3 010 -> illegal
    send(1, 5, 1, 9, 8, 7, 32'h0);           // SRA
    send(1, 1, 1, 9, 8, 7, 32'h0);           // alt with f3 001 -> illegal
    send(1, 7, 0, 9, 8, 7, 32'h0);           // AND
    send(10, 0, 0, 1, 1, 1, 32'h0);          // type 10 -> illegal
    send(15, 0, 0, 1, 1, 1, 32'h0);          // type 15 -> illegal
    drain();

    // Fill to DEPTH with the consumer stalled
    for (int i = 0; i < DEPTH; i++) send(3, 0, 0, i + 1, 0, 0, 32'(i * 3 + 1));
    in_valid = 1'b0;
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'h0);
    // Request while full and popping: refused, only the pop happens
    out_ready = 1'b1;
    send(3, 0, 0, 20, 0, 0, 32'h0000_0055);
    in_valid = 1'b0;
    check("full_pushpop_count", 32'(count), 32'(DEPTH - 1));
    drain();

    // Push/pop pairs at occupancy 1 across the pointer wrap
    send(1, 0, 0, 1, 2, 3, 32'h0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(3, 4, 0, i, i + 1, 0, 32'(i * 17));
      check("pair_count_occ1", 32'(count), 32'h1);
    end
    drain();

    // Push/pop pairs at occupancy DEPTH-1
    for (int i = 0; i < DEPTH - 1; i++) send(9, 1, 0, 0, i, i + 2, 32'(i * 40));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(4, 0, 0, i + 3, 0, 0, 32'(i) << 12);
      check("pair_count_occ7", 32'(count), 32'(DEPTH - 1));
    end
    drain();

    // Reset mid-operation with a legal request present
    for (int i = 0; i < 5; i++) send(1, 0, 0, i, 1, 2, 32'h0);
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'h5);
    rst = 1'b1;
    send(1, 0, 0, 7, 7, 7, 32'h0);
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h1);
    idle(1);

    // Reset with an illegal request present: no err afterwards
    send(1, 0, 0, 1, 1, 1, 32'h0);
    send(2, 2, 0, 1, 1, 1, 32'h0000_0004);
    rst = 1'b1;
    send(0, 0, 0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_ill_err", 32'(err), 32'h0);
    check("rst_ill_count", 32'(count), 32'h0);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
